// File: rtl/imm_sel_stage_pkg.sv
// imm_sel_stage_pkg
//   Shared RISC-V decode constants: base-ISA opcodes that carry an
//   immediate, the shift funct3 codes, and the immediate format encoding
//   presented on out_fmt.
package imm_sel_stage_pkg;

    // Immediate format code driven on out_fmt.
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    // funct3 of the immediate shifts (SLLI/SLLIW and SRLI/SRAI/SRLIW/SRAIW).
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    // True for an OP-IMM / OP-IMM-32 immediate shift.
    function automatic logic is_imm_shift(input logic [6:0] opcode, input logic [2:0] funct3);
        return ((opcode == OPC_OP_IMM) || (opcode == OPC_OP_IMM_32)) &&
               ((funct3 == F3_SLL) || (funct3 == F3_SRX));
    endfunction

endpackage

// File: rtl/imm_sel_stage_extract.sv
// imm_extract
//   Purely combinational immediate extraction for one RV32/RV64 base-ISA
//   instruction.
//   Ports:
//     instr : raw 32-bit instruction
//     imm   : immediate, sign-extended to XLEN (shift amounts zero-extended)
//     fmt   : immediate format code (FMT_NONE for opcodes without one)
module imm_extract
    import imm_sel_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHAMT_MASK = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Every standard immediate fits in 32 bits with instr[31] as its sign,
    // so build it at 32 bits and widen once with a signed cast.
    logic signed [31:0] imm32;

    always_comb begin
        fmt   = FMT_NONE;
        imm32 = '0;
        imm   = '0;

        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_OP_IMM_32: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                fmt   = FMT_NONE;
                imm32 = '0;
            end
        endcase

        imm = XLEN'(imm32);

        // Shift immediates carry only the shift amount; the funct6/funct7
        // bits above it are opcode extension, not part of the value.
        // RV64 OP-IMM shifts use a 6-bit amount, the *W forms and RV32 use 5.
        if ((SHAMT_MASK != 0) && is_imm_shift(opcode, funct3)) begin
            fmt = FMT_SHAMT;
            if ((XLEN == 64) && (opcode == OPC_OP_IMM))
                imm = XLEN'(instr[25:20]);
            else
                imm = XLEN'(instr[24:20]);
        end
    end

endmodule

// File: rtl/imm_sel_stage.sv
// imm_sel_stage
//   Immediate-select pipeline stage. Decodes the immediate at acceptance
//   and holds up to two decoded entries in a skid FIFO; the head entry is
//   presented downstream straight from flops.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     flush                : synchronous discard of all held entries
//     in_valid/in_ready    : upstream handshake (in_ready is registered state)
//     in_instr, in_tag     : raw instruction and sideband tag (PC)
//     out_valid/out_ready  : downstream handshake
//     out_imm, out_fmt     : extended immediate and its format code
//     out_instr, out_tag   : pass-through of the entry
module imm_sel_stage
    import imm_sel_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 32,
    parameter int SHAMT_MASK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Decode happens on the input side so the stored entry is already final.
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;

    imm_extract #(
        .XLEN       (XLEN),
        .SHAMT_MASK (SHAMT_MASK)
    ) u_extract (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    entry_t new_entry;
    assign new_entry = '{imm: dec_imm, fmt: dec_fmt, instr: in_instr, tag: in_tag};

    // head is always the oldest entry; tail is only meaningful at count 2.
    logic [1:0] count_q, count_d;
    entry_t     head_q,  head_d;
    entry_t     tail_q,  tail_d;

    logic push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_imm   = head_q.imm;
    assign out_fmt   = head_q.fmt;
    assign out_instr = head_q.instr;
    assign out_tag   = head_q.tag;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = new_entry;
                    else                 tail_d = new_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // push implies count<2 and pop implies count>0, so count
                    // is 1: the incoming entry replaces the departing head.
                    head_d = new_entry;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_imm_sel_stage.sv
module tb_imm_sel_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, ov32, rdy64, ov64;
    logic [31:0] imm32, ins32, tag32, ins64, tag64;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_sel_stage #(.XLEN(32), .TAG_W(32), .SHAMT_MASK(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_instr(ins32), .out_tag(tag32)
    );

    imm_sel_stage #(.XLEN(64), .TAG_W(32), .SHAMT_MASK(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_instr(ins64), .out_tag(tag64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v_ins [11];
    logic [63:0] v_e32 [11];
    logic [63:0] v_e64 [11];
    logic [2:0]  v_fmt [11];
    logic [31:0] got_q [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        v_ins = '{32'hFFF00093, 32'hFE000EE3, 32'h800000B7, 32'h03F09093, 32'h4030D093,
                  32'hFE112C23, 32'h0080006F, 32'h002081B3, 32'h12345197, 32'h01F0909B,
                  32'h7FF00013};
        v_e32 = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'h80000000, 64'd31, 64'd3,
                  64'hFFFFFFF8, 64'd8, 64'd0, 64'h12345000, 64'd31, 64'h7FF};
        v_e64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'd63, 64'd3,
                  64'hFFFFFFFFFFFFFFF8, 64'd8, 64'd0, 64'h12345000, 64'd31, 64'h7FF};
        v_fmt = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd6, 3'd2, 3'd5, 3'd0, 3'd4, 3'd6, 3'd1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        #2;
        chk("rst_valid", ov32, 0);
        chk("rst_ready", rdy32, 1);
        chk("rst_imm32", imm32, 0);
        chk("rst_imm64", imm64, 0);
        chk("rst_fmt",   fmt32, 0);
        chk("rst_tag",   tag32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Decode vectors, one at a time with out_ready high.
        for (int i = 0; i < 11; i++) begin
            chk("idle_valid", ov32, 0);
            in_valid = 1'b1; in_instr = v_ins[i]; in_tag = 100 + i;
            step();
            in_valid = 1'b0;
            chk("lat_valid32", ov32, 1);
            chk("lat_valid64", ov64, 1);
            chk("imm32",  imm32, v_e32[i]);
            chk("imm64",  imm64, v_e64[i]);
            chk("fmt32",  fmt32, v_fmt[i]);
            chk("fmt64",  fmt64, v_fmt[i]);
            chk("instr",  ins32, v_ins[i]);
            chk("tag",    tag32, 100 + i);
            step();
        end
        chk("drain_valid", ov32, 0);

        // Backpressure: three offered, two accepted.
        out_ready = 1'b0;
        in_instr  = 32'hFFF00093;
        for (int t = 10; t < 13; t++) begin
            in_valid = 1'b1; in_tag = t;
            step();
        end
        chk("bp_ready", rdy32, 0);
        chk("bp_head",  tag32, 10);
        step();
        chk("bp_hold_tag", tag32, 10);
        chk("bp_hold_imm", imm32, 32'hFFFFFFFF);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ov32) got_q.push_back(tag32);
            if (in_valid && rdy32) begin
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
        end
        chk("bp_count", got_q.size(), 3);
        for (int i = 0; i < got_q.size() && i < 3; i++) chk("bp_order", got_q[i], 10 + i);
        chk("bp_empty", ov32, 0);

        // Occupancy 1 with accept and transfer every cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 20;
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_tag = 21 + k;
            chk("tp_valid", ov32, 1);
            chk("tp_ready", rdy32, 1);
            chk("tp_tag",   tag32, 20 + k);
            step();
        end
        in_valid = 1'b0;
        chk("tp_last", tag32, 30);
        step();
        chk("tp_empty", ov32, 0);

        // Flush with two held plus a pending offer.
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 40; step();
        in_tag = 41; step();
        in_tag = 42; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", ov32, 0);
        chk("fl_ready", rdy32, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("fl_gone", ov32, 0);
            step();
        end
        in_valid = 1'b1; in_tag = 43; step();
        in_valid = 1'b0;
        chk("fl_next_valid", ov32, 1);
        chk("fl_next_tag",   tag32, 43);
        step();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 50; step();
        in_tag = 51; step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("ar_valid", ov32, 0);
        chk("ar_ready", rdy32, 1);
        chk("ar_imm",   imm64, 0);
        chk("ar_fmt",   fmt32, 0);
        chk("ar_instr", ins32, 0);
        chk("ar_tag",   tag32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h4030D093; in_tag = 52;
        step();
        in_valid = 1'b0;
        chk("pr_valid", ov32, 1);
        chk("pr_tag",   tag32, 52);
        chk("pr_imm",   imm64, 3);
        chk("pr_fmt",   fmt64, 6);
        step();
        chk("pr_empty", ov32, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_sel_stage.md
IMM_SEL_STAGE -- requirements
Module: imm_sel_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate/output width; legal values 32, 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (PC) carried with each instruction.
REQ-003 SHALL have parameter SHAMT_MASK, default 1; 1 enables shift-amount extraction for shift immediates.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-007 SHALL have port in_valid, input, 1, upstream entry present.
REQ-008 SHALL have port in_ready, output, 1, stage can accept an entry.
REQ-009 SHALL have port in_instr, input, 32, raw RV32/RV64 base-ISA instruction.
REQ-010 SHALL have port in_tag, input, TAG_W, sideband tag.
REQ-011 SHALL have port out_valid, output, 1, entry available downstream.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 SHALL have port out_imm, output, XLEN, selected, extended immediate.
REQ-014 SHALL have port out_fmt, output, 3, format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6.
REQ-015 SHALL have ports out_instr, output, 32, and out_tag, output, TAG_W, pass-through of the entry.

Function
REQ-016 SHALL accept an entry when in_valid && in_ready; transfer downstream when out_valid && out_ready.
REQ-017 SHALL decode by opcode in_instr[6:0]: 0000011/0010011/1100111/0011011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; all others -> NONE, imm 0.
REQ-018 SHALL, for I/S/B/U/J, sign-extend the standard RISC-V immediate from its top bit (instr[31]) to XLEN bits; B and J have bit0 = 0; U has bits[11:0] = 0 and sign-extends from bit 31 when XLEN=64.
REQ-019 SHALL, when SHAMT_MASK=1, set fmt SHAMT for opcode 0010011/0011011 with funct3 001 or 101, imm = zero-extended instr[24:20] (XLEN=32 or opcode 0011011) or instr[25:20] (XLEN=64, opcode 0010011); funct6/funct7 bits are excluded.
REQ-020 SHALL decode at acceptance and store the result, giving 1-cycle latency: an entry accepted in cycle N is presented with out_valid=1 in cycle N+1 at the earliest.
REQ-021 SHALL buffer up to 2 entries (skid FIFO) and deliver them in acceptance order with no loss or duplication.
REQ-022 SHALL drive in_ready from registered state only: in_ready=1 iff fewer than 2 entries are held.
REQ-023 SHALL, when full, accept in the same cycle as a transfer only if already deasserted in_ready permits; a full buffer accepts nothing that cycle.
REQ-024 SHALL, when an accept and a transfer occur in the same cycle, keep the occupancy unchanged.
REQ-025 SHALL hold out_imm/out_fmt/out_instr/out_tag stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, when flush=1, empty the buffer next cycle, ignore any same-cycle accept, and deassert out_valid; flush overrides all other inputs.

Reset
REQ-027 SHALL, on rst_n=0, immediately clear the occupancy: out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE, out_instr=0, out_tag=0; this holds mid-operation and discards buffered entries.
REQ-028 SHALL resume accepting on the first clk edge after rst_n rises.

Structure
REQ-029 SHALL place the out_fmt encodings and the opcode constants in the shared RISC-V decode package.
REQ-030 SHALL implement extraction as one combinational sub-module imm_extract (instr -> imm, fmt, parameterised by XLEN and SHAMT_MASK), instantiated once at the input side.

Verification
REQ-031 SHALL test XLEN=32: 0xFFF00093 (addi -1) -> imm 0xFFFFFFFF, fmt I, out_valid one cycle after accept; 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt B.
REQ-032 SHALL test XLEN=64: 0x800000B7 (lui) -> 0xFFFFFFFF80000000, fmt U; 0x03F09093 (slli 63) -> 63, fmt SHAMT; 0x4030D093 (srai 3) -> 3, fmt SHAMT.
REQ-033 SHALL test backpressure: out_ready=0, offer 3 entries -> 2 accepted, in_ready=0; raise out_ready -> tags emerge in order, third accepted, none lost.
REQ-034 SHALL test simultaneous accept and transfer at occupancy 1 for 10 cycles -> occupancy stays 1, throughput 1 entry per cycle.
REQ-035 SHALL test flush with 2 entries held plus in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries never appear.
REQ-036 SHALL test rst_n pulsed low mid-stream -> outputs reach REQ-027 values without a clk edge; the first post-reset entry is delivered correctly.
